// File: rtl/in_port_if.sv
// Handshake and bus signals between the input device, the CPU bus mux and the
// input-port controller. The controller sits on the slave side.
interface in_port_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] dev_data;
    logic              dev_valid;
    logic              dev_ready;
    logic              InPortout;
    logic              StatusOut;
    logic              int_ack;
    logic [DATA_W-1:0] BusMuxIn_InPort;
    logic              data_avail;
    logic              overrun;
    logic              irq;

    modport slave (
        input  dev_data, dev_valid, InPortout, StatusOut, int_ack,
        output dev_ready, BusMuxIn_InPort, data_avail, overrun, irq
    );

    modport master (
        output dev_data, dev_valid, InPortout, StatusOut, int_ack,
        input  dev_ready, BusMuxIn_InPort, data_avail, overrun, irq
    );
endinterface

// File: rtl/in_port_ctrl.sv
// Input-port controller: buffers device words in a small circular FIFO and
// presents the head word or a status word to the Mini SRC InPort bus source.
module in_port_ctrl #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 2,
    parameter int IRQ_LEVEL = 1
) (
    input logic     clock,
    input logic     clear,
    in_port_if.slave port
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] IRQ_CNT  = (ADDR_W + 1)'(IRQ_LEVEL);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;
    logic              overrun_q;
    logic              overrun_next;
    logic              irq_q;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] bus_word;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Ready depends only on registered occupancy, never on dev_valid.
    assign push = port.dev_valid && !full;
    assign pop  = port.InPortout && !empty;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // A word offered while full is dropped; setting beats the acknowledge.
    always_comb begin
        overrun_next = overrun_q;
        if (port.dev_valid && full) begin
            overrun_next = 1'b1;
        end else if (port.int_ack) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count     <= count_next;
            overrun_q <= overrun_next;
            irq_q     <= (count_next >= IRQ_CNT) || overrun_next;
        end
    end

    // Storage carries data only, so it is left out of the reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= port.dev_data;
        end
    end

    always_comb begin
        status_word                 = '0;
        status_word[0]              = empty;
        status_word[1]              = full;
        status_word[2]              = overrun_q;
        status_word[3]              = irq_q;
        status_word[8 +: ADDR_W+1]  = count;
    end

    always_comb begin
        bus_word = '0;
        if (port.StatusOut) begin
            bus_word = status_word;
        end else if (port.InPortout && !empty) begin
            bus_word = mem[rd_ptr];
        end
    end

    assign port.dev_ready       = !full;
    assign port.data_avail      = !empty;
    assign port.overrun         = overrun_q;
    assign port.irq             = irq_q;
    assign port.BusMuxIn_InPort = bus_word;
endmodule

// File: tb/tb_in_port_ctrl.sv
// Directed bench for in_port_ctrl: one instance with IRQ_LEVEL=4 for FIFO,
// status and overrun behaviour, one with IRQ_LEVEL=2 for the irq threshold.
module tb_in_port_ctrl;
    logic clock = 1'b0;
    logic clear;
    int   total = 0;
    int   bad   = 0;

    in_port_if #(.DATA_W(32)) ia ();
    in_port_if #(.DATA_W(32)) ib ();

    in_port_ctrl #(.DATA_W(32), .DEPTH(4), .ADDR_W(2), .IRQ_LEVEL(4)) dut_a (
        .clock(clock), .clear(clear), .port(ia)
    );
    in_port_ctrl #(.DATA_W(32), .DEPTH(4), .ADDR_W(2), .IRQ_LEVEL(2)) dut_b (
        .clock(clock), .clear(clear), .port(ib)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] w);
        ia.dev_data  = w;
        ia.dev_valid = 1'b1;
        step();
        ia.dev_valid = 1'b0;
    endtask

    task automatic push_b(input logic [31:0] w);
        ib.dev_data  = w;
        ib.dev_valid = 1'b1;
        step();
        ib.dev_valid = 1'b0;
    endtask

    task automatic pop_a(input string tag, input logic [31:0] exp);
        ia.InPortout = 1'b1;
        #1;
        chk(tag, ia.BusMuxIn_InPort, exp);
        step();
        ia.InPortout = 1'b0;
    endtask

    task automatic status_a(input string tag, input logic [31:0] exp);
        ia.StatusOut = 1'b1;
        #1;
        chk(tag, ia.BusMuxIn_InPort, exp);
        ia.StatusOut = 1'b0;
    endtask

    initial begin
        clear        = 1'b0;
        ia.dev_data  = '0; ia.dev_valid = 1'b0; ia.InPortout = 1'b0;
        ia.StatusOut = 1'b0; ia.int_ack = 1'b0;
        ib.dev_data  = '0; ib.dev_valid = 1'b0; ib.InPortout = 1'b0;
        ib.StatusOut = 1'b0; ib.int_ack = 1'b0;
        repeat (2) step();

        // reset state
        chk("rst_ready", {31'd0, ia.dev_ready}, 32'd1);
        chk("rst_avail", {31'd0, ia.data_avail}, 32'd0);
        chk("rst_irq", {31'd0, ia.irq}, 32'd0);
        chk("rst_ovr", {31'd0, ia.overrun}, 32'd0);
        chk("rst_bus", ia.BusMuxIn_InPort, 32'd0);
        clear = 1'b1;
        step();
        status_a("rst_status", 32'h0000_0001);

        // ordering and pointer wrap
        push_a(32'h1111_1111);
        chk("avail_after_push", {31'd0, ia.data_avail}, 32'd1);
        push_a(32'h2222_2222);
        push_a(32'h3333_3333);
        push_a(32'h4444_4444);
        chk("full_ready", {31'd0, ia.dev_ready}, 32'd0);
        status_a("full_status", 32'h0000_040A);
        pop_a("rd1", 32'h1111_1111);
        pop_a("rd2", 32'h2222_2222);
        chk("ready_after_pop", {31'd0, ia.dev_ready}, 32'd1);
        push_a(32'h5555_5555);
        push_a(32'h6666_6666);
        pop_a("rd3", 32'h3333_3333);
        pop_a("rd4", 32'h4444_4444);
        pop_a("rd5", 32'h5555_5555);
        pop_a("rd6", 32'h6666_6666);
        chk("drained_avail", {31'd0, ia.data_avail}, 32'd0);
        pop_a("rd_empty", 32'h0000_0000);
        status_a("empty_status", 32'h0000_0001);

        // overrun
        push_a(32'h0000_0001);
        push_a(32'h0000_0002);
        push_a(32'h0000_0003);
        push_a(32'h0000_0004);
        push_a(32'hDEAD_BEEF);
        chk("ovr_set", {31'd0, ia.overrun}, 32'd1);
        chk("ovr_irq", {31'd0, ia.irq}, 32'd1);
        status_a("ovr_status", 32'h0000_040E);
        pop_a("ovr_rd1", 32'h0000_0001);
        pop_a("ovr_rd2", 32'h0000_0002);
        pop_a("ovr_rd3", 32'h0000_0003);
        pop_a("ovr_rd4", 32'h0000_0004);
        chk("ovr_sticky", {31'd0, ia.overrun}, 32'd1);
        chk("ovr_irq_empty", {31'd0, ia.irq}, 32'd1);
        ia.int_ack = 1'b1;
        step();
        ia.int_ack = 1'b0;
        chk("ack_ovr", {31'd0, ia.overrun}, 32'd0);
        chk("ack_irq", {31'd0, ia.irq}, 32'd0);

        // simultaneous push and pop
        push_a(32'h0000_00B0);
        push_a(32'h0000_00B1);
        ia.dev_data  = 32'hAAAA_0000;
        ia.dev_valid = 1'b1;
        ia.InPortout = 1'b1;
        #1;
        chk("sim_head", ia.BusMuxIn_InPort, 32'h0000_00B0);
        step();
        ia.dev_valid = 1'b0;
        ia.InPortout = 1'b0;
        status_a("sim_count", 32'h0000_0200);
        pop_a("sim_rd1", 32'h0000_00B1);
        pop_a("sim_rd2", 32'hAAAA_0000);
        ia.dev_data  = 32'h0000_00C0;
        ia.dev_valid = 1'b1;
        ia.InPortout = 1'b1;
        #1;
        chk("empty_push_pop_bus", ia.BusMuxIn_InPort, 32'h0000_0000);
        step();
        ia.dev_valid = 1'b0;
        ia.InPortout = 1'b0;
        status_a("empty_push_pop_count", 32'h0000_0100);

        // status read, alone and together with a data read
        push_a(32'h0000_00C1);
        push_a(32'h0000_00C2);
        status_a("status3", 32'h0000_0300);
        ia.StatusOut = 1'b1;
        ia.InPortout = 1'b1;
        #1;
        chk("status_and_read", ia.BusMuxIn_InPort, 32'h0000_0300);
        step();
        ia.StatusOut = 1'b0;
        ia.InPortout = 1'b0;
        status_a("status_after_pop", 32'h0000_0200);
        pop_a("head_after_status_pop", 32'h0000_00C1);

        // irq threshold at fill count 2
        push_b(32'h0000_0E01);
        chk("thr_one", {31'd0, ib.irq}, 32'd0);
        push_b(32'h0000_0E02);
        chk("thr_two", {31'd0, ib.irq}, 32'd1);
        ib.InPortout = 1'b1;
        step();
        ib.InPortout = 1'b0;
        chk("thr_fall", {31'd0, ib.irq}, 32'd0);
        push_b(32'h0000_0E03);
        chk("thr_rise_again", {31'd0, ib.irq}, 32'd1);

        // asynchronous reset mid-stream with count 3 and a word on offer
        push_a(32'h0000_00C3);
        push_a(32'h0000_00C4);
        status_a("pre_rst_count", 32'h0000_0300);
        ia.dev_data  = 32'h0000_00C5;
        ia.dev_valid = 1'b1;
        clear = 1'b0;
        #1;
        chk("arst_ready", {31'd0, ia.dev_ready}, 32'd1);
        chk("arst_avail", {31'd0, ia.data_avail}, 32'd0);
        chk("arst_irq", {31'd0, ia.irq}, 32'd0);
        chk("arst_ovr", {31'd0, ia.overrun}, 32'd0);
        chk("arst_bus", ia.BusMuxIn_InPort, 32'h0000_0000);
        chk("arst_irq_b", {31'd0, ib.irq}, 32'd0);
        chk("arst_avail_b", {31'd0, ib.data_avail}, 32'd0);
        status_a("arst_status", 32'h0000_0001);
        step();
        clear        = 1'b1;
        ia.dev_valid = 1'b0;
        step();
        chk("arst_discarded", {31'd0, ia.data_avail}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
